rf_write_ctrl: RTL and testbench
================================

RF_WRITE_CTRL -- requirements
Module: rf_write_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge; downstream register file commits on falling edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 wb_we / wb_wa / wb_wd  input  1/5/32  pipeline writeback request, address, data; no handshake.
REQ-004 lu_valid / lu_wa / lu_wd  input  1/5/32  long-latency unit result request, address, data.
REQ-005 lu_ready  output  1  long-latency result accepted this cycle.
REQ-006 iss_valid / iss_wa  input  1/5  long-latency op issued; marks iss_wa pending.
REQ-007 chk_ra1 / chk_ra2 / chk_wa  input  5 each  decode-stage sources and destination checked for hazards.
REQ-008 hazard_stall  output  1  decode must stall.
REQ-009 wb_hold  output  1  pipeline must hold its writeback stage this cycle.
REQ-010 rf_we / rf_wa / rf_wd  output  1/5/32  single write port to the register file.
REQ-011 init_busy  output  1  register clear sequence in progress.

Function
REQ-012 FSM states SHALL be INIT and RUN; reset enters INIT with sweep counter = 1.
REQ-013 In INIT: rf_we=1, rf_wa=counter, rf_wd=0; counter increments each cycle; after writing address 31, next state RUN (31 cycles total).
REQ-014 In INIT: init_busy=1, hazard_stall=1, lu_ready=0, wb_we and iss_valid ignored.
REQ-015 In RUN: init_busy=0; a request with address 0 is a null request and produces rf_we=0.
REQ-016 Priority: pipeline writeback wins the port unless wb_hold=1; while wb_hold=1 the long-latency unit wins and wb_we is ignored (upstream re-presents it next cycle).
REQ-017 lu_ready = RUN & (wb_hold | no non-null wb request); lu_valid with lu_wa=0 is accepted with no write.
REQ-018 Write port outputs SHALL be combinational from the winning request; rf_we=0, rf_wa=0, rf_wd=0 when no winner in RUN.
REQ-019 Starvation counter counts consecutive cycles with lu_valid=1 and lu_ready=0; reaching 4 sets registered wb_hold=1 for exactly one cycle; counter clears on any lu handshake or lu_valid=0.
REQ-020 Scoreboard: 32-bit pending vector; bit 0 always 0; iss_valid sets pend[iss_wa]; lu handshake clears pend[lu_wa].
REQ-021 Simultaneous set and clear of the same bit: set wins.
REQ-022 hazard_stall in RUN = pend[chk_ra1] | pend[chk_ra2] | pend[chk_wa], from registered pend only (no same-cycle bypass of clears).
REQ-023 Upstream asserts iss_valid only when hazard_stall=0; wb to a pending register is illegal and unchecked.

Reset
REQ-024 Reset values: state INIT, counter 1, pend all 0, starvation counter 0, wb_hold 0.
REQ-025 Outputs during reset: rf_we=1, rf_wa=1, rf_wd=0, init_busy=1, hazard_stall=1, lu_ready=0, wb_hold=0.
REQ-026 Reset asserted mid-INIT or mid-RUN SHALL abort immediately, discard pending state and restart the sweep from address 1.

Structure
REQ-027 Shared package: FSM state encoding, REG_COUNT=32, ADDR_W=5, DATA_W=32, STARVE_LIMIT=4.
REQ-028 One sub-module, rf_scoreboard (pending vector, set/clear, three read ports); arbitration, FSM and write mux stay in the top.

Verification
REQ-029 Reset release -> rf_we=1 for 31 cycles, rf_wa 1..31, rf_wd=0; init_busy falls in cycle 32.
REQ-030 RUN, wb_we=1 wb_wa=5 wb_wd=0xDEADBEEF with lu_valid=1 lu_wa=7 -> rf_wa=5, lu_ready=0; next cycle wb_we=0 -> rf_wa=7, lu_ready=1.
REQ-031 wb_we=1 (wa=3) every cycle, lu_valid=1 (wa=9) held -> lu_ready=0 for 4 cycles, wb_hold=1 in cycle 5 with rf_wa=9, lu_ready=1.
REQ-032 iss_valid wa=10, then chk_ra1=10 -> hazard_stall=1 until the cycle after lu handshake on wa=10; chk_ra2=0 never stalls.
REQ-033 Same-cycle iss_valid wa=12 and lu handshake wa=12 -> pend[12] remains 1, hazard_stall=1 on chk_wa=12.
REQ-034 Reset pulse with pend[10]=1 mid-RUN -> pend cleared, sweep restarts at rf_wa=1, lu_ready=0 throughout INIT.

Source files
------------

// File: rtl/rf_write_ctrl_pkg.sv
// Shared constants, types and helpers for the register-file write controller.
package rf_write_ctrl_pkg;

    localparam int unsigned REG_COUNT    = 32;
    localparam int unsigned ADDR_W       = 5;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned STARVE_W     = $clog2(STARVE_LIMIT);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef logic [ADDR_W-1:0]    addr_t;
    typedef logic [DATA_W-1:0]    data_t;
    typedef logic [REG_COUNT-1:0] regvec_t;

    function automatic regvec_t addr_onehot(input addr_t a);
        regvec_t v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on result.
module rf_scoreboard
    import rf_write_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  set_en,
    input  addr_t set_wa,
    input  logic  clr_en,
    input  addr_t clr_wa,
    input  addr_t ra1,
    input  addr_t ra2,
    input  addr_t ra3,
    output logic  rd1,
    output logic  rd2,
    output logic  rd3
);

    regvec_t pend_q;
    regvec_t pend_d;
    regvec_t set_mask;
    regvec_t clr_mask;

    always_comb begin
        set_mask = set_en ? addr_onehot(set_wa) : '0;
        clr_mask = clr_en ? addr_onehot(clr_wa) : '0;
        // Set is applied after clear so a same-cycle set on the same bit wins.
        pend_d    = (pend_q & ~clr_mask) | set_mask;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign rd1 = pend_q[ra1];
    assign rd2 = pend_q[ra2];
    assign rd3 = pend_q[ra3];

endmodule

// File: rtl/rf_write_ctrl.sv
// Register-file write-port arbiter: clears the file after reset, then shares the
// single write port between pipeline writeback and a long-latency unit.
module rf_write_ctrl
    import rf_write_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  wb_we,
    input  addr_t wb_wa,
    input  data_t wb_wd,
    input  logic  lu_valid,
    input  addr_t lu_wa,
    input  data_t lu_wd,
    output logic  lu_ready,
    input  logic  iss_valid,
    input  addr_t iss_wa,
    input  addr_t chk_ra1,
    input  addr_t chk_ra2,
    input  addr_t chk_wa,
    output logic  hazard_stall,
    output logic  wb_hold,
    output logic  rf_we,
    output addr_t rf_wa,
    output data_t rf_wd,
    output logic  init_busy
);

    logic [0:0]          state_q, state_d;
    addr_t               cnt_q, cnt_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                wb_hold_q, wb_hold_d;

    logic run;
    logic wb_req;
    logic lu_hs;
    logic starved;
    logic pend1, pend2, pend3;

    assign run      = (state_q == ST_RUN);
    assign wb_req   = wb_we && (wb_wa != '0);
    assign lu_ready = run && (wb_hold_q || !wb_req);
    assign lu_hs    = lu_valid && lu_ready;
    assign starved  = run && lu_valid && !lu_ready;

    always_comb begin
        rf_we = 1'b0;
        rf_wa = '0;
        rf_wd = '0;
        if (!run) begin
            rf_we = 1'b1;
            rf_wa = cnt_q;
        end else if (!wb_hold_q && wb_req) begin
            rf_we = 1'b1;
            rf_wa = wb_wa;
            rf_wd = wb_wd;
        end else if (lu_hs && (lu_wa != '0)) begin
            rf_we = 1'b1;
            rf_wa = lu_wa;
            rf_wd = lu_wd;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!run) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == ADDR_W'(REG_COUNT - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    // Hold pulse fires on the cycle after the limit-th starved cycle.
    always_comb begin
        starve_d  = '0;
        wb_hold_d = 1'b0;
        if (starved) begin
            if (starve_q == STARVE_W'(STARVE_LIMIT - 1)) begin
                wb_hold_d = 1'b1;
            end else begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_INIT;
            cnt_q     <= ADDR_W'(1);
            starve_q  <= '0;
            wb_hold_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            wb_hold_q <= wb_hold_d;
        end
    end

    rf_scoreboard u_scoreboard (
        .clk    (clk),
        .reset  (reset),
        .set_en (run && iss_valid),
        .set_wa (iss_wa),
        .clr_en (lu_hs),
        .clr_wa (lu_wa),
        .ra1    (chk_ra1),
        .ra2    (chk_ra2),
        .ra3    (chk_wa),
        .rd1    (pend1),
        .rd2    (pend2),
        .rd3    (pend3)
    );

    assign hazard_stall = !run || pend1 || pend2 || pend3;
    assign wb_hold      = wb_hold_q;
    assign init_busy    = !run;

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Directed bench for rf_write_ctrl; expectations queued by the driver, checked by a monitor.
module tb_rf_write_ctrl;

    logic        clk;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        lu_valid;
    logic [4:0]  lu_wa;
    logic [31:0] lu_wd;
    logic        lu_ready;
    logic        iss_valid;
    logic [4:0]  iss_wa;
    logic [4:0]  chk_ra1;
    logic [4:0]  chk_ra2;
    logic [4:0]  chk_wa;
    logic        hazard_stall;
    logic        wb_hold;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        init_busy;

    typedef struct {
        string       name;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        lr;
        logic        wh;
        logic        hz;
        logic        ib;
    } exp_t;

    exp_t sb_q[$];
    int   total;
    int   passed;

    rf_write_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .wb_we        (wb_we),
        .wb_wa        (wb_wa),
        .wb_wd        (wb_wd),
        .lu_valid     (lu_valid),
        .lu_wa        (lu_wa),
        .lu_wd        (lu_wd),
        .lu_ready     (lu_ready),
        .iss_valid    (iss_valid),
        .iss_wa       (iss_wa),
        .chk_ra1      (chk_ra1),
        .chk_ra2      (chk_ra2),
        .chk_wa       (chk_wa),
        .hazard_stall (hazard_stall),
        .wb_hold      (wb_hold),
        .rf_we        (rf_we),
        .rf_wa        (rf_wa),
        .rf_wd        (rf_wd),
        .init_busy    (init_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input string field, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, field, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Monitor: outputs are valid every cycle, compared mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check(e.name, "rf_we",        32'(rf_we),        32'(e.we));
            check(e.name, "rf_wa",        32'(rf_wa),        32'(e.wa));
            check(e.name, "rf_wd",        rf_wd,             e.wd);
            check(e.name, "lu_ready",     32'(lu_ready),     32'(e.lr));
            check(e.name, "wb_hold",      32'(wb_hold),      32'(e.wh));
            check(e.name, "hazard_stall", 32'(hazard_stall), 32'(e.hz));
            check(e.name, "init_busy",    32'(init_busy),    32'(e.ib));
        end
    end

    task automatic step(input string nm, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic lr, input logic wh,
                        input logic hz, input logic ib);
        exp_t e;
        e.name = nm;
        e.we   = we;
        e.wa   = wa;
        e.wd   = wd;
        e.lr   = lr;
        e.wh   = wh;
        e.hz   = hz;
        e.ib   = ib;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_we     = 1'b0;
        wb_wa     = '0;
        wb_wd     = '0;
        lu_valid  = 1'b0;
        lu_wa     = '0;
        lu_wd     = '0;
        iss_valid = 1'b0;
        iss_wa    = '0;
        chk_ra1   = '0;
        chk_ra2   = '0;
        chk_wa    = '0;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        reset  = 1'b1;
        idle();
        @(posedge clk);
        #1;
        step("reset", 1'b1, 5'd1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        reset = 1'b0;

        // Sweep with noise on every request input; all of it must be ignored.
        wb_we = 1'b1; wb_wa = 5'd4; wb_wd = 32'h44;
        lu_valid = 1'b1; lu_wa = 5'd6; lu_wd = 32'h66;
        iss_valid = 1'b1; iss_wa = 5'd20; chk_ra1 = 5'd20;
        for (int k = 1; k <= 31; k++) begin
            step($sformatf("init%0d", k), 1'b1, 5'(k), 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        end

        idle();
        chk_ra1 = 5'd20;
        step("run_idle", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'hDEADBEEF;
        lu_valid = 1'b1; lu_wa = 5'd7; lu_wd = 32'h12345678;
        step("wb_wins", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
        wb_we = 1'b0;
        step("lu_after_wb", 1'b1, 5'd7, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b0);

        wb_we = 1'b1; wb_wa = 5'd0; wb_wd = 32'h55;
        lu_wa = 5'd0; lu_wd = 32'h66;
        step("null_req", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        wb_wa = 5'd3; wb_wd = 32'h33;
        lu_wa = 5'd9; lu_wd = 32'h99;
        for (int k = 1; k <= 4; k++) begin
            step($sformatf("starve%0d", k), 1'b1, 5'd3, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        step("hold", 1'b1, 5'd9, 32'h99, 1'b1, 1'b1, 1'b0, 1'b0);
        step("post_hold", 1'b1, 5'd3, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0);

        idle();
        iss_valid = 1'b1; iss_wa = 5'd10;
        step("iss10", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        iss_valid = 1'b0; chk_ra1 = 5'd10; chk_ra2 = 5'd0;
        step("chk10", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        lu_valid = 1'b1; lu_wa = 5'd10; lu_wd = 32'hAA;
        step("lu10_no_bypass", 1'b1, 5'd10, 32'hAA, 1'b1, 1'b0, 1'b1, 1'b0);
        lu_valid = 1'b0;
        step("clr10", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        idle();
        iss_valid = 1'b1; iss_wa = 5'd12;
        lu_valid = 1'b1; lu_wa = 5'd12; lu_wd = 32'hBB;
        step("set_clr12", 1'b1, 5'd12, 32'hBB, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        chk_wa = 5'd12;
        step("set_wins12", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);

        idle();
        iss_valid = 1'b1; iss_wa = 5'd10;
        step("iss10b", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        iss_valid = 1'b0; chk_ra1 = 5'd10;
        step("pend10", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Mid-run reset: pending bits dropped, sweep restarts, lu never accepted.
        idle();
        reset = 1'b1;
        wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'h77;
        lu_valid = 1'b1; lu_wa = 5'd5; lu_wd = 32'h88;
        iss_valid = 1'b1; iss_wa = 5'd11;
        step("reset_mid", 1'b1, 5'd1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        reset = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            step($sformatf("reinit%0d", k), 1'b1, 5'(k), 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        idle();
        chk_ra1 = 5'd10; chk_ra2 = 5'd11; chk_wa = 5'd12;
        step("pend_cleared", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
